// File: rtl/cc_parity_pkg.sv
// Shared definitions for the XOR parity path: FSM state encoding, framing
// constants and the parity helper used by both generator and checker.
package cc_parity_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } ccParityState_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Parity bit that should accompany a word whose XOR reduction is acc.
    function automatic logic par_calc(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

endpackage

// File: rtl/cc_parity_acc.sv
// Registered XOR accumulator: folds one bit per enabled cycle into a running
// parity; clear wins over enable.
module cc_parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic bitIn,
    output logic acc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= 1'b0;
        end else if (enable) begin
            acc <= acc ^ bitIn;
        end
    end

endmodule

// File: rtl/cc_parity_rx.sv
// Serial start/data/parity/stop receiver that recomputes parity by XOR
// accumulation and reports data plus parity and framing errors.
module cc_parity_rx
    import cc_parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                  CC_ParityRx_CLOCK_50,
    input  logic                  CC_ParityRx_RESET_InHigh,
    input  logic                  CC_ParityRx_Bit_In,
    input  logic                  CC_ParityRx_Strobe_In,
    output logic [DATA_WIDTH-1:0] CC_ParityRx_Data_Out,
    output logic                  CC_ParityRx_Valid_Out,
    output logic                  CC_ParityRx_ParityErr_Out,
    output logic                  CC_ParityRx_FrameErr_Out,
    output logic                  CC_ParityRx_Busy_Out,
    output ccParityState_t        CC_ParityRx_State_Out
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    // Output handshake: Valid_Out is a one-cycle pulse with no backpressure;
    // Data_Out and both error flags are meaningful only while it is high and
    // otherwise hold the last reported frame.
    ccParityState_t        state;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [CW-1:0]         count;
    logic                  perr;
    logic                  acc;
    logic                  accClear;
    logic                  accEnable;

    assign accClear  = CC_ParityRx_Strobe_In && (state == IDLE) &&
                       (CC_ParityRx_Bit_In == START_BIT);
    assign accEnable = CC_ParityRx_Strobe_In && (state == DATA);

    cc_parity_acc uAcc (
        .clk    (CC_ParityRx_CLOCK_50),
        .rst    (CC_ParityRx_RESET_InHigh),
        .clear  (accClear),
        .enable (accEnable),
        .bitIn  (CC_ParityRx_Bit_In),
        .acc    (acc)
    );

    always_ff @(posedge CC_ParityRx_CLOCK_50) begin
        if (CC_ParityRx_RESET_InHigh) begin
            state                     <= IDLE;
            shiftReg                  <= '0;
            count                     <= '0;
            perr                      <= 1'b0;
            CC_ParityRx_Data_Out      <= '0;
            CC_ParityRx_Valid_Out     <= 1'b0;
            CC_ParityRx_ParityErr_Out <= 1'b0;
            CC_ParityRx_FrameErr_Out  <= 1'b0;
        end else begin
            // The pulse drops on the next edge whether or not a strobe arrives.
            CC_ParityRx_Valid_Out <= 1'b0;
            if (CC_ParityRx_Strobe_In) begin
                case (state)
                    IDLE: begin
                        if (CC_ParityRx_Bit_In == START_BIT) begin
                            state    <= DATA;
                            shiftReg <= '0;
                            count    <= '0;
                        end
                    end
                    DATA: begin
                        shiftReg <= shiftReg | (DATA_WIDTH'(CC_ParityRx_Bit_In) << count);
                        count    <= count + 1'b1;
                        if (count == CW'(DATA_WIDTH - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        perr  <= (CC_ParityRx_Bit_In != par_calc(acc, PARITY_ODD != 0));
                        state <= STOP;
                    end
                    STOP: begin
                        CC_ParityRx_Data_Out      <= shiftReg;
                        CC_ParityRx_ParityErr_Out <= perr;
                        CC_ParityRx_FrameErr_Out  <= ~CC_ParityRx_Bit_In;
                        CC_ParityRx_Valid_Out     <= 1'b1;
                        state <= (CC_ParityRx_Bit_In == STOP_BIT) ? IDLE : WAIT_HIGH;
                    end
                    WAIT_HIGH: begin
                        // A held-low break line must not be read as new start bits.
                        if (CC_ParityRx_Bit_In == STOP_BIT) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign CC_ParityRx_Busy_Out  = (state != IDLE);
    assign CC_ParityRx_State_Out = state;

endmodule

// File: doc/cc_parity_rx.md
Name: cc_parity_rx

Overview:
Serial frame receiver that deserialises a start/data/parity/stop bit stream and checks it against the configured parity. It is the checking end of the XOR-based parity generator path: the transmitter appends parity, and this block recomputes parity by XOR accumulation and flags mismatches. It sits between a bit-timing front end, which supplies one sample strobe per bit, and any parallel consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, LSB first; legal range 1..16.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
CC_ParityRx_CLOCK_50  input  1  system clock; all logic on the rising edge.
CC_ParityRx_RESET_InHigh  input  1  synchronous, active-high reset.
CC_ParityRx_Bit_In  input  1  serial line level; idle level is 1.
CC_ParityRx_Strobe_In  input  1  bit-sample enable; the line is sampled only in cycles where this is 1.
CC_ParityRx_Data_Out  output  DATA_WIDTH  last received data word; held until the next frame completes.
CC_ParityRx_Valid_Out  output  1  one-cycle pulse when a frame completes.
CC_ParityRx_ParityErr_Out  output  1  parity mismatch for the reported frame; qualified by Valid_Out.
CC_ParityRx_FrameErr_Out  output  1  stop bit was 0 for the reported frame; qualified by Valid_Out.
CC_ParityRx_Busy_Out  output  1  1 whenever the state is not IDLE.

Behaviour:
- Reset is synchronous and active-high. It takes priority over everything else, and state goes to IDLE.
- Reset values: Data_Out = 0, Valid_Out = 0, ParityErr_Out = 0, FrameErr_Out = 0, Busy_Out = 0. The bit counter and the XOR accumulator are both cleared.
- Frame format: start bit (0), then DATA_WIDTH data bits LSB first, then parity bit, then stop bit (1). A frame is DATA_WIDTH+3 strobed samples.
- Gating: every state transition and every register update other than reset happens only in cycles where Strobe_In = 1. When Strobe_In = 0, all state holds, including gaps of any length mid-frame.
- State machine: IDLE, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a strobed 0 moves to DATA, clearing the shift register, the bit counter and the accumulator. A strobed 1 stays in IDLE.
  - DATA: on each strobed bit, shift the bit into position count (LSB first), acc <= acc ^ bit, count++. After sample number DATA_WIDTH, go to PARITY.
  - PARITY: store perr = (bit != (acc ^ PARITY_ODD)), then go to STOP.
  - STOP: present the result. Data_Out <= shift register, ParityErr_Out <= perr, FrameErr_Out <= ~bit, and Valid_Out = 1 on the next clock edge. If bit = 1, go to IDLE. If bit = 0, go to WAIT_HIGH.
  - WAIT_HIGH: a strobed 1 goes to IDLE; strobed 0s are ignored. This stops a held-low (break) line from being taken as back-to-back start bits.
- Latency: Valid_Out is high for exactly one clock, in the cycle after the strobed stop-bit sample, regardless of Strobe_In in that cycle.
- Error flags: they update only together with a Valid_Out pulse and hold their value between pulses. Data is reported even on error.
- Back-to-back frames: a strobed 0 arriving the strobe immediately after a good stop bit is accepted as a new start, so there is no dead bit.
- Reset mid-frame discards the partial frame and produces no Valid_Out pulse.
- The bit counter is ceil(log2(DATA_WIDTH+1)) bits wide and never wraps within a frame.

Decomposition:
- Shared package cc_parity_pkg: state encoding constants (IDLE=0, DATA=1, PARITY=2, STOP=3, WAIT_HIGH=4), the START_BIT=0 and STOP_BIT=1 constants, and a parity function par_calc(acc, odd). The matching parity generator reuses the same package.
- One natural sub-module: cc_parity_acc, a registered XOR accumulator with clear and enable inputs, built on the existing two-input XOR gate.

Test Plan:
- Even parity, DATA_WIDTH=8, strobe every cycle. Send 0xA5: bits 0, 1,0,1,0,0,1,0,1, 0, 1. Expect a single Valid pulse, Data=0xA5, ParityErr=0, FrameErr=0, Busy back to 0 after the frame.
- Parity error: send 0x01 with parity bit 0 and stop 1. Expect Valid, Data=0x01, ParityErr=1, FrameErr=0. With PARITY_ODD=1 the same frame gives ParityErr=0.
- Framing/break: send 0x3C with correct parity and stop=0, then five strobed 0s, then a 1, then a valid 0x55 frame. Expect one Valid with FrameErr=1 and Data=0x3C, no frames during the low period, then Valid with Data=0x55 and no errors.
- Gapped strobes: send 0xA5 with Strobe_In high only every 4th cycle and random 0/1 on Bit_In between strobes. Expect results identical to the first scenario, with Valid one cycle after the stop strobe.
- Reset mid-frame: assert reset after the 4th data bit of 0xFF. Expect all outputs 0 and no Valid. A following 0x0F frame gives Data=0x0F and no errors.
- Back-to-back: send 0x12 then 0x34 with no idle bit between them. Expect two Valid pulses DATA_WIDTH+3 strobes apart, carrying the correct data and no errors.
